// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches a 32-bit instruction window over a
// req/valid handshake, and steps the one-hot phase (f, r, x, m, w) that
// sequences the decoder and datapath. Stops on HLT or an unknown opcode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        cr_taken,
  input  logic [1:0]  br,
  input  logic        cc,
  input  logic [31:0] branch_target,
  output logic [4:0]  phase,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StF,
    StR,
    StX,
    StM,
    StW,
    StHalt
  } state_e;

  localparam logic [7:0] OpHlt = 8'hF4;

  localparam logic [4:0] PhNone = 5'b00000;
  localparam logic [4:0] PhF    = 5'b00001;
  localparam logic [4:0] PhR    = 5'b00010;
  localparam logic [4:0] PhX    = 5'b00100;
  localparam logic [4:0] PhM    = 5'b01000;
  localparam logic [4:0] PhW    = 5'b10000;

  state_e      state_q;
  logic [1:0]  len_q;
  logic [1:0]  fetch_len;
  logic        taken;
  logic [31:0] next_pc;

  // Instruction length from the leading opcode byte; 0 marks an unknown opcode.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd0;
    case (op)
      8'hF4:                           len = 2'd1;
      8'h8B, 8'h89, 8'h01, 8'h29, 8'h39,
      8'h21, 8'h09, 8'h31, 8'hF7:      len = 2'd2;
      8'h66, 8'h83, 8'hC1, 8'h90:      len = 2'd3;
      default:                         len = 2'd0;
    endcase
    return len;
  endfunction

  // Decode the incoming window and resolve the next PC for the W exit edge.
  always_comb begin
    fetch_len = op_len(imem_rdata[31:24]);
    taken     = cr_taken & ((br == 2'b10) | ((br == 2'b01) & cc));
    // 32-bit add wraps silently; the carry out is intentionally dropped.
    next_pc   = taken ? branch_target : (pc + {30'd0, len_q});
  end

  // The fetch address is always the architectural PC.
  assign imem_addr = pc;

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q  <= StIdle;
      pc       <= RESET_PC;
      ir       <= 32'd0;
      len_q    <= 2'd0;
      phase    <= PhNone;
      imem_req <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q  <= StReq;
          imem_req <= 1'b1;
          phase    <= PhNone;
        end
        StReq: begin
          // Hold request and address steady until memory answers.
          if (imem_valid) begin
            ir       <= imem_rdata;
            len_q    <= fetch_len;
            imem_req <= 1'b0;
            if (fetch_len != 2'd0) begin
              state_q <= StF;
              phase   <= PhF;
            end else begin
              state_q <= StHalt;
              phase   <= PhNone;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
          end
        end
        StF: begin
          state_q <= StR;
          phase   <= PhR;
        end
        StR: begin
          state_q <= StX;
          phase   <= PhX;
        end
        StX: begin
          state_q <= StM;
          phase   <= PhM;
        end
        StM: begin
          state_q <= StW;
          phase   <= PhW;
        end
        StW: begin
          phase <= PhNone;
          if (ir[31:24] == OpHlt) begin
            // HLT leaves the PC pointing at itself.
            state_q <= StHalt;
            halted  <= 1'b1;
          end else begin
            pc       <= next_pc;
            state_q  <= StReq;
            imem_req <= 1'b1;
          end
        end
        StHalt: begin
          // Only reset leaves this state.
          phase    <= PhNone;
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state_q  <= StIdle;
          phase    <= PhNone;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: drives a hand-scripted memory and branch
// unit, checks PC, phase sequence, handshake and stop behaviour.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstd;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        cr_taken;
  logic [1:0]  br;
  logic        cc;
  logic [31:0] branch_target;
  logic [4:0]  phase;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        halted;
  logic        illegal;

  int vectors;
  int miscompares;

  localparam logic [24:0] PhSeq = 25'b10000_01000_00100_00010_00001;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rstd          (rstd),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .cr_taken      (cr_taken),
    .br            (br),
    .cc            (cc),
    .branch_target (branch_target),
    .phase         (phase),
    .ir            (ir),
    .pc            (pc),
    .halted        (halted),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) at negedges until the DUT requests a fetch.
  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Serve one instruction: answer after 'waits' cycles, record the phase
  // sequence, and drive the branch inputs in W. Optional noise asserts a
  // taken branch during F..M, which must be ignored.
  task automatic run_instr(input logic [31:0] data, input int waits, input logic take,
                           input logic [1:0] br_v, input logic cc_v,
                           input logic [31:0] tgt, input bit noise,
                           output bit got, output logic [31:0] addr_seen,
                           output int req_cnt, output logic [24:0] phseq,
                           output logic [31:0] ir_seen);
    phseq   = '0;
    ir_seen = '0;
    req_cnt = 0;
    wait_req(got);
    addr_seen = imem_addr;
    if (got) begin
      for (int i = 0; i < waits; i++) begin
        if (imem_req === 1'b1 && imem_addr === addr_seen && phase === 5'd0) req_cnt++;
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
      end
      imem_valid = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = 32'h5A5A_5A5A;
      for (int k = 0; k < 5; k++) begin
        phseq[k*5 +: 5] = phase;
        if (k == 1) ir_seen = ir;
        if (k == 4) begin
          cr_taken      = take;
          br            = br_v;
          cc            = cc_v;
          branch_target = tgt;
        end else if (noise) begin
          cr_taken      = 1'b1;
          br            = 2'b10;
          cc            = 1'b1;
          branch_target = 32'h0000_0BAD;
        end
        @(negedge clk);
        cr_taken      = 1'b0;
        br            = 2'b00;
        cc            = 1'b0;
        branch_target = 32'h0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstd = 1'b0;
    #2;
    @(negedge clk);
    rstd = 1'b1;
  endtask

  task automatic test_reset();
    rstd = 1'b0;
    #7;
    vectors++;
    if (phase !== 5'd0 || pc !== 32'd0 || ir !== 32'd0 || imem_req !== 1'b0 ||
        halted !== 1'b0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got phase=%b pc=%h ir=%h req=%b h=%b il=%b want all zero",
               phase, pc, ir, imem_req, halted, illegal);
    end
    @(negedge clk);
    rstd = 1'b1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_cycle_req: got %b want 0", imem_req);
    end
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL first_req: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    bit got; logic [31:0] a; int rc; logic [24:0] ps; logic [31:0] irs;
    run_instr(32'h0102_0000, 3, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL first_fetch_req: got timeout want req"); end
    vectors++;
    if (irs !== 32'h0102_0000) begin
      miscompares++; $display("FAIL first_ir: got %h want 01020000", irs);
    end
    vectors++;
    if (ps !== PhSeq) begin
      miscompares++; $display("FAIL first_phases: got %b want %b", ps, PhSeq);
    end
    vectors++;
    if (rc !== 3) begin
      miscompares++; $display("FAIL req_hold: got %0d want 3", rc);
    end
    vectors++;
    if (pc !== 32'd2 || imem_addr !== 32'd2 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL first_pc: got pc=%h addr=%h req=%b want 2 2 1", pc, imem_addr, imem_req);
    end
  endtask

  task automatic test_sequential();
    bit got; logic [31:0] a; int rc; logic [24:0] ps; logic [31:0] irs;
    // Jump to 0x10 first, then a 3-byte opcode with stray branch strobes in F..M.
    run_instr(32'h9000_0000, 0, 1'b1, 2'b10, 1'b0, 32'h10, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (pc !== 32'h10) begin miscompares++; $display("FAIL jump_0x10: got %h want 10", pc); end
    run_instr(32'h8312_3456, 1, 1'b0, 2'b10, 1'b1, 32'h777, 1'b1, got, a, rc, ps, irs);
    vectors++;
    if (a !== 32'h10 || pc !== 32'h13) begin
      miscompares++; $display("FAIL seq_83: got addr=%h pc=%h want 10 13", a, pc);
    end
    vectors++;
    if (ps !== PhSeq) begin
      miscompares++; $display("FAIL seq_phases: got %b want %b", ps, PhSeq);
    end
  endtask

  task automatic test_branches();
    bit got; logic [31:0] a; int rc; logic [24:0] ps; logic [31:0] irs;
    run_instr(32'h9000_0000, 0, 1'b1, 2'b10, 1'b0, 32'h40, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (pc !== 32'h40) begin miscompares++; $display("FAIL br_uncond: got %h want 40", pc); end
    run_instr(32'h9000_0000, 0, 1'b1, 2'b01, 1'b0, 32'h80, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (pc !== 32'h43) begin miscompares++; $display("FAIL br_cond_nt: got %h want 43", pc); end
    run_instr(32'h9000_0000, 2, 1'b1, 2'b01, 1'b1, 32'h40, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (pc !== 32'h40) begin miscompares++; $display("FAIL br_cond_t: got %h want 40", pc); end
    run_instr(32'h8900_0000, 0, 1'b1, 2'b00, 1'b1, 32'h99, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (pc !== 32'h42) begin miscompares++; $display("FAIL br_none: got %h want 42", pc); end
    run_instr(32'h9000_0000, 0, 1'b0, 2'b10, 1'b1, 32'h99, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (pc !== 32'h45) begin miscompares++; $display("FAIL br_no_commit: got %h want 45", pc); end
  endtask

  task automatic test_wrap();
    bit got; logic [31:0] a; int rc; logic [24:0] ps; logic [31:0] irs;
    run_instr(32'h9000_0000, 0, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 1'b0, got, a, rc, ps, irs);
    run_instr(32'h6600_0000, 0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (a !== 32'hFFFF_FFFE || pc !== 32'h1) begin
      miscompares++; $display("FAIL wrap: got addr=%h pc=%h want fffffffe 00000001", a, pc);
    end
  endtask

  task automatic test_halt();
    bit got; logic [31:0] a; int rc; logic [24:0] ps; logic [31:0] irs;
    int bad;
    run_instr(32'h9000_0000, 0, 1'b1, 2'b10, 1'b0, 32'h20, 1'b0, got, a, rc, ps, irs);
    run_instr(32'hF400_0000, 0, 1'b1, 2'b10, 1'b0, 32'h80, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (ps !== PhSeq) begin
      miscompares++; $display("FAIL hlt_phases: got %b want %b", ps, PhSeq);
    end
    vectors++;
    if (halted !== 1'b1 || illegal !== 1'b0 || pc !== 32'h20 || phase !== 5'd0) begin
      miscompares++;
      $display("FAIL hlt_state: got h=%b il=%b pc=%h ph=%b want 1 0 20 0",
               halted, illegal, pc, phase);
    end
    bad = 0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0102_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || phase !== 5'd0 || halted !== 1'b1 || pc !== 32'h20) bad++;
    end
    imem_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL hlt_sticky: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_illegal();
    bit got;
    int bad;
    do_reset();
    wait_req(got);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL ill_req: got timeout want req"); end
    imem_valid = 1'b1;
    imem_rdata = 32'hFF12_3456;
    @(negedge clk);
    imem_valid = 1'b0;
    vectors++;
    if (illegal !== 1'b1 || halted !== 1'b1 || phase !== 5'd0 || imem_req !== 1'b0 ||
        ir !== 32'hFF12_3456) begin
      miscompares++;
      $display("FAIL ill_stop: got il=%b h=%b ph=%b req=%b ir=%h want 1 1 0 0 ff123456",
               illegal, halted, phase, imem_req, ir);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (phase !== 5'd0 || imem_req !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL ill_sticky: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_async_reset();
    bit got; logic [31:0] a; int rc; logic [24:0] ps; logic [31:0] irs;
    do_reset();
    run_instr(32'h9000_0000, 0, 1'b1, 2'b10, 1'b0, 32'h40, 1'b0, got, a, rc, ps, irs);
    imem_valid = 1'b1;
    imem_rdata = 32'h0102_0000;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (phase !== 5'b00100 || pc !== 32'h40) begin
      miscompares++; $display("FAIL pre_rst_x: got ph=%b pc=%h want 00100 40", phase, pc);
    end
    #2 rstd = 1'b0;
    #1;
    vectors++;
    if (phase !== 5'd0 || pc !== 32'd0 || ir !== 32'd0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: got ph=%b pc=%h ir=%h req=%b want 0 0 0 0",
               phase, pc, ir, imem_req);
    end
    @(negedge clk);
    rstd = 1'b1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL rst_idle: got req=%b want 0", imem_req);
    end
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_resume_req: got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    run_instr(32'h2900_0000, 0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, got, a, rc, ps, irs);
    vectors++;
    if (pc !== 32'd2 || ps !== PhSeq) begin
      miscompares++; $display("FAIL rst_resume: got pc=%h ph=%b want 2 %b", pc, ps, PhSeq);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rstd          = 1'b0;
    imem_valid    = 1'b0;
    imem_rdata    = 32'h0;
    cr_taken      = 1'b0;
    br            = 2'b00;
    cc            = 1'b0;
    branch_target = 32'h0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branches();
    test_wrap();
    test_halt();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
